booth_multiplier_seq: RTL and testbench
=======================================

# booth_multiplier_seq

Sequential radix-2 Booth multiplier for the CPU ALU. It takes two signed 32-bit operands and produces a signed 64-bit product split into HI and LO words. It runs one add/subtract-and-shift step per clock and uses a start/busy/done handshake. It sits beside the 32-bit carry-lookahead adder in the ALU, fed by the same RA/RB operand buses, and drives the HI/LO result registers.

## Interface
- WIDTH, 32: operand width in bits. The product is 2·WIDTH bits.
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- RA  in  WIDTH  multiplicand, two's complement.
- RB  in  WIDTH  multiplier, two's complement.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when HI/LO become valid.
- HI  out  WIDTH  upper product word.
- LO  out  WIDTH  lower product word.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: iterating; busy=1.
  - DONE: one cycle; done=1, busy=0.
- Internal registers:
  - M: WIDTH+1 bits, sign-extended RA.
  - A: WIDTH+1-bit accumulator.
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - count: clog2(WIDTH+1) bits.
- Accept: start=1 with state IDLE or DONE, at the sampling edge. Effects:
  - M←sext(RA), A←0, Q←RB, q_m1←0, count←WIDTH; state→RUN.
- RUN step, one per edge, selected by {Q[0],q_m1}:
  - 01: A←A+M.
  - 10: A←A−M, computed as A+~M+1.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_m1} by 1 (A MSB replicated), and count←count−1.
- Completion: on the edge where count goes 1→0:
  - HI←A[WIDTH-1:0] and LO←Q, both taken after the shift.
  - state→DONE.
- DONE lasts exactly one cycle, then state→IDLE unless a new start is accepted.
- Width rule: A is WIDTH+1 bits so that −2^(WIDTH−1) as multiplicand cannot overflow. Every product is exact in 2·WIDTH bits, with no saturation and no flags.
- HI/LO hold their value from completion until the next completion. A new start does not clear them.
- start while busy=1 is ignored; RA/RB changes during RUN have no effect.

## Timing
- Reset (clear=0): state=IDLE, busy=0, done=0, HI=0, LO=0, and all internal registers 0. Takes effect immediately, asynchronously.
- Reset during RUN aborts the operation; no done pulse follows. Normal operation resumes on the first edge after clear returns to 1.
- Latency: accepting edge E0. Iterations happen at E1..E_WIDTH. HI/LO update and done=1 after edge E_WIDTH, i.e. WIDTH+1 cycles from request to done for WIDTH=32.
- busy: 1 from after E0 through E_WIDTH; 0 in DONE.
- Back-to-back: start=1 during the DONE cycle is accepted at that edge, so done and acceptance coincide. Throughput is one product per WIDTH+1 cycles.
- start=1 held continuously in IDLE causes restarts every WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared ALU package `alu_pkg`:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Booth select codes.
  - WIDTH default.
- Sub-module `booth_addsub`: WIDTH+1-bit add/subtract with inputs A, M, sub, and output sum. Subtraction uses inverted M with carry-in 1. Purely combinational.
- Top level holds the FSM, counter, and shift registers.

## Test plan
- Reset: hold clear=0, toggle start and RA/RB → HI=0, LO=0, busy=0, done=0 throughout.
- RA=7, RB=0xFFFFFFFD (−3), start → done exactly 33 cycles after the start edge; HI=0xFFFFFFFF, LO=0xFFFFFFEB; single-cycle done.
- RA=RB=0x80000000 → HI=0x40000000, LO=0x00000000. Then RA=0xFFFFFFFF, RB=0x80000000 → HI=0x00000000, LO=0x80000000.
- Random signed pairs (≥1000) checked against a 64-bit reference product. HI/LO must stay unchanged during RUN.
- start pulsed at cycles 5 and 20 of a RUN with different RA/RB → ignored, first result unaffected. start held during DONE → new operation accepted that edge, second done 33 cycles later.
- clear=0 asserted at iteration 10 → immediate IDLE, HI=LO=0, no done. Then RA=3, RB=4 → HI=0, LO=12.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states, Booth select codes, default width.
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth select codes, indexed by {Q[0], q_m1}
    localparam logic [1:0] SEL_ADD = 2'b01;
    localparam logic [1:0] SEL_SUB = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// Combinational (WIDTH+1)-bit add/subtract used by the Booth step.
module booth_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] A,
    input  logic [WIDTH:0] M,
    input  logic           sub,
    output logic [WIDTH:0] sum
);

    // Subtraction is A + ~M + 1, sharing one adder with the add path
    always_comb begin
        sum = A + (sub ? ~M : M) + {{WIDTH{1'b0}}, sub};
    end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock,
// start/busy/done handshake, registered HI/LO product words.
module booth_multiplier_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] RA,
    input  logic [WIDTH-1:0] RB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH:0]   m;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [CW-1:0]    count;

    logic [1:0]       sel;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   a_next;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;

    assign sel = {q[0], q_m1};

    booth_addsub #(.WIDTH(WIDTH)) u_addsub (
        .A   (a),
        .M   (m),
        .sub (sel == SEL_SUB),
        .sum (sum)
    );

    // Pick the accumulator update, then arithmetic-shift {A,Q} right by one
    always_comb begin
        a_next = (sel == SEL_ADD || sel == SEL_SUB) ? sum : a;
        a_sh   = {a_next[WIDTH], a_next[WIDTH:1]};
        q_sh   = {a_next[0], q[WIDTH-1:1]};
    end

    // FSM, datapath registers and registered handshake/result outputs
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            m     <= '0;
            a     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        m     <= {RA[WIDTH-1], RA};
                        a     <= '0;
                        q     <= RB;
                        q_m1  <= 1'b0;
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a     <= a_sh;
                    q     <= q_sh;
                    q_m1  <= q[0];
                    count <= count - CW'(1);
                    // Last iteration: publish the post-shift product
                    if (count == CW'(1)) begin
                        HI    <= a_sh[WIDTH-1:0];
                        LO    <= q_sh;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq: directed vector table,
// randomized products against a 64-bit arithmetic reference, and
// handshake / reset corner sequences.
module tb_booth_multiplier_seq;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] RA, RB;
    logic        busy, done;
    logic [31:0] HI, LO;

    int pass_cnt = 0;
    int total    = 0;

    booth_multiplier_seq #(.WIDTH(32)) dut (
        .clock (clock),
        .clear (clear),
        .start (start),
        .RA    (RA),
        .RB    (RB),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: exact signed product of two 32-bit operands
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint px, py;
        px = longint'($signed(x));
        py = longint'($signed(y));
        return 64'(px * py);
    endfunction

    // Launch one product; returns result at the done cycle, edges counted
    // from the accepting edge (inclusive), and whether busy/HI/LO held during RUN
    task automatic run_op(input logic [31:0] ra, input logic [31:0] rb,
                          output logic [63:0] res, output int edges, output bit stable);
        logic [63:0] prev;
        @(negedge clock);
        RA = ra; RB = rb; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        RA = $urandom; RB = $urandom;
        edges  = 1;
        stable = 1'b1;
        prev   = {HI, LO};
        while (!done && edges < 40) begin
            if (!busy || {HI, LO} !== prev) stable = 1'b0;
            @(negedge clock);
            edges++;
        end
        res = {HI, LO};
    endtask

    vec_t        vecs[8];
    logic [63:0] res;
    int          edges;
    bit          stable;
    bit          bad;

    initial begin
        vecs[0] = '{32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[2] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000};
        vecs[3] = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[7] = '{32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C};

        // Reset held while inputs toggle: outputs must stay zero
        clear = 1'b0; start = 1'b0; RA = '0; RB = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            start = ~start; RA = $urandom; RB = $urandom;
            chk("reset_outputs", {busy, done, HI, LO}, 66'd0);
        end
        @(negedge clock);
        start = 1'b0;
        clear = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].ra, vecs[i].rb, res, edges, stable);
            chk($sformatf("vec%0d_product", i), res, {vecs[i].hi, vecs[i].lo});
            chk($sformatf("vec%0d_latency", i), 64'(edges), 64'd33);
            chk($sformatf("vec%0d_stable", i), 64'(stable), 64'd1);
            chk($sformatf("vec%0d_busy_done", i), 64'(busy), 64'd0);
            @(negedge clock);
            chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
        end

        // Random signed pairs; failures are aggregated to keep output short
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            if (i % 8 == 0) ra = 32'h80000000;
            if (i % 11 == 0) rb = 32'h80000000;
            run_op(ra, rb, res, edges, stable);
            if (!bad && (res !== ref_mul(ra, rb) || edges != 33 || !stable)) begin
                bad = 1'b1;
                chk("random_product", res, ref_mul(ra, rb));
                chk("random_latency", 64'(edges), 64'd33);
                chk("random_stable", 64'(stable), 64'd1);
            end
        end
        chk("random_all_ok", 64'(bad), 64'd0);

        // start pulses during RUN are ignored
        @(negedge clock);
        RA = 32'd5; RB = 32'hFFFFFFF7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        edges = 1;
        while (!done && edges < 40) begin
            start = (edges == 5 || edges == 20);
            RA = 32'd1000 + 32'(edges); RB = 32'd77;
            @(negedge clock);
            edges++;
        end
        start = 1'b0;
        chk("ignore_product", {HI, LO}, ref_mul(32'd5, 32'hFFFFFFF7));
        chk("ignore_latency", 64'(edges), 64'd33);

        // start held during DONE: accepted at that edge, second done 33 edges later
        RA = 32'h0001_2345; RB = 32'hFFFF_0F0F; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("b2b_done_dropped", 64'(done), 64'd0);
        chk("b2b_busy", 64'(busy), 64'd1);
        edges = 1;
        while (!done && edges < 40) begin
            @(negedge clock);
            edges++;
        end
        chk("b2b_latency", 64'(edges), 64'd33);
        chk("b2b_product", {HI, LO}, ref_mul(32'h0001_2345, 32'hFFFF_0F0F));

        // Reset mid-run aborts: immediate zeros, no done afterwards
        @(negedge clock);
        RA = 32'h1234_5678; RB = 32'h0BAD_F00D; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        clear = 1'b0;
        #1;
        chk("abort_immediate", {busy, done, HI, LO}, 66'd0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (done || busy) bad = 1'b1;
        end
        clear = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) bad = 1'b1;
        end
        chk("abort_no_done", 64'(bad), 64'd0);
        chk("abort_hilo_zero", {HI, LO}, 64'd0);
        run_op(32'd3, 32'd4, res, edges, stable);
        chk("after_abort_product", res, 64'd12);
        chk("after_abort_latency", 64'(edges), 64'd33);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
